uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high; one clock per design.
REQ-004 SHALL have port tx_data  input  8  byte to send; sampled only in the cycle tx_start is high.
REQ-005 SHALL have port tx_start  input  1  one-cycle request pulse, raised when the CPU stores to the UART transmit-data register (0x40000018).
REQ-006 SHALL have port status_clr  input  1  one-cycle pulse, raised when the CPU reads the UART control register (0x40000020); clears sticky flags.
REQ-007 SHALL have port uart_txd  output  1  serial line; idle high.
REQ-008 SHALL have port tx_busy  output  1  high while a frame is on the line or a byte is held.
REQ-009 SHALL have port tx_done  output  1  sticky: a frame completed since the last clear.
REQ-010 SHALL have port tx_overrun  output  1  sticky: a request was dropped since the last clear.

Function
REQ-011 SHALL send 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP; IDLE->START on accepted request; START->DATA after one bit time; DATA->STOP after the 8th bit time; STOP->IDLE, or STOP->START when the holding register is full, after one bit time.
REQ-013 SHALL use a bit-time counter (16 bit, counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary) and a 3-bit data-bit index that wraps 7->0 on DATA exit.
REQ-014 SHALL, on tx_start in IDLE, load tx_data into the shift register; uart_txd goes low on the first rising edge after the tx_start cycle (1-cycle latency).
REQ-015 SHALL provide one holding register: tx_start while the FSM is not IDLE and holding is empty -> byte stored in holding, no other effect.
REQ-016 SHALL, at STOP end with holding full, move holding into the shift register and enter START on the same edge: no idle cycles between frames; holding becomes empty.
REQ-017 SHALL, on tx_start while holding is full, drop the byte, set tx_overrun, and leave the current frame and held byte untouched.
REQ-018 SHALL set tx_done on the edge that ends each STOP bit, including back-to-back frames.
REQ-019 SHALL clear tx_done and tx_overrun on status_clr; when a set and status_clr coincide in one cycle, set wins.
REQ-020 SHALL drive tx_busy = (state != IDLE) OR holding full, registered/combinational from registers only; no combinational path from any input to any output.
REQ-021 SHALL drive uart_txd from a register (glitch-free).

Reset
REQ-022 SHALL, on reset high, immediately force state IDLE, uart_txd=1, tx_busy=0, tx_done=0, tx_overrun=0, counters=0, holding empty; independent of clk.
REQ-023 SHALL abort any frame in progress on reset mid-frame (line returns high at once); held byte discarded; no resumption after release.
REQ-024 SHALL accept tx_start on the first rising edge after reset deasserts.

Verification (CLKS_PER_BIT=4, frame = 40 cycles)
REQ-025 SHALL pass: tx_start with tx_data=0x55 in IDLE -> line low for cycles 1-4, then 1,0,1,0,1,0,1,0 each 4 cycles, high 4 cycles; tx_done=1 at cycle 40; tx_busy 1 for cycles 1-40.
REQ-026 SHALL pass: 0xA3 started, 0x0F pulsed at cycle 10 -> 0x0F start bit begins at cycle 41 with no idle gap; two tx_done sets; tx_busy stays 1 through cycle 80.
REQ-027 SHALL pass: 0x11 started, 0x22 pulsed at cycle 5, 0x33 at cycle 6 -> 0x33 dropped, tx_overrun=1 from cycle 7; line carries 0x11 then 0x22 only.
REQ-028 SHALL pass: status_clr coinciding with the tx_done-setting edge -> tx_done=1; status_clr one cycle later -> tx_done=0, tx_overrun=0.
REQ-029 SHALL pass: reset asserted at cycle 17 of a 0xFF frame with 0x80 held -> uart_txd=1, tx_busy=0 immediately; after release, tx_start with 0x01 sends a clean frame of 0x01 only.
REQ-030 SHALL pass: tx_start on the first edge after reset release with tx_data=0x00 -> start bit at the next edge, 8 zero bits, stop bit, total 40 cycles.

Source files
------------

// File: rtl/uart_tx_if.sv
// Transmit-side bus of the UART: CPU request/clear strobes in, serial line and status flags out.
// master = CPU/bus side, slave = the transmitter itself.
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       status_clr;
   logic       uart_txd;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_overrun;

   modport master (
      output tx_data, tx_start, status_clr,
      input  uart_txd, tx_busy, tx_done, tx_overrun
   );

   modport slave (
      input  tx_data, tx_start, status_clr,
      output uart_txd, tx_busy, tx_done, tx_overrun
   );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register and sticky done/overrun flags.
// Every output comes straight from a register, so no input reaches an output combinationally.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 5208
) (
   input logic     clk,
   input logic     reset,
   uart_tx_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

   logic [1:0]  state_q,    state_d;
   logic [15:0] cnt_q,      cnt_d;
   logic [2:0]  bitIdx_q,   bitIdx_d;
   logic [7:0]  shift_q,    shift_d;
   logic [7:0]  hold_q,     hold_d;
   logic        holdFull_q, holdFull_d;
   logic        txd_q,      txd_d;
   logic        done_q,     done_d;
   logic        overrun_q,  overrun_d;

   logic bitEnd;
   logic setDone;
   logic setOverrun;

   assign bitEnd = (cnt_q == BIT_LAST);

   // The next line level is computed alongside the state so uart_txd changes on the same edge as the FSM.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bitIdx_d   = bitIdx_q;
      shift_d    = shift_q;
      hold_d     = hold_q;
      holdFull_d = holdFull_q;
      txd_d      = txd_q;
      setDone    = 1'b0;
      setOverrun = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (holdFull_q) begin
               shift_d    = hold_q;
               holdFull_d = 1'b0;
               state_d    = S_START;
               cnt_d      = 16'd0;
               txd_d      = 1'b0;
            end else if (bus.tx_start) begin
               shift_d = bus.tx_data;
               state_d = S_START;
               cnt_d   = 16'd0;
               txd_d   = 1'b0;
            end
         end
         S_START: begin
            if (bitEnd) begin
               cnt_d    = 16'd0;
               bitIdx_d = 3'd0;
               state_d  = S_DATA;
               txd_d    = shift_q[0];
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            if (bitEnd) begin
               cnt_d    = 16'd0;
               bitIdx_d = bitIdx_q + 3'd1;
               shift_d  = {1'b0, shift_q[7:1]};
               if (bitIdx_q == 3'd7) begin
                  state_d = S_STOP;
                  txd_d   = 1'b1;
               end else begin
                  txd_d = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            if (bitEnd) begin
               cnt_d   = 16'd0;
               setDone = 1'b1;
               if (holdFull_q) begin
                  shift_d    = hold_q;
                  holdFull_d = 1'b0;
                  state_d    = S_START;
                  txd_d      = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
      endcase

      // A request that cannot start a frame directly goes to holding, or is dropped if holding is occupied.
      if (bus.tx_start && ((state_q != S_IDLE) || holdFull_q)) begin
         if (holdFull_q) begin
            setOverrun = 1'b1;
         end else begin
            hold_d     = bus.tx_data;
            holdFull_d = 1'b1;
         end
      end

      done_d    = setDone    ? 1'b1 : (bus.status_clr ? 1'b0 : done_q);
      overrun_d = setOverrun ? 1'b1 : (bus.status_clr ? 1'b0 : overrun_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         bitIdx_q   <= 3'd0;
         shift_q    <= 8'd0;
         hold_q     <= 8'd0;
         holdFull_q <= 1'b0;
         txd_q      <= 1'b1;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bitIdx_q   <= bitIdx_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         holdFull_q <= holdFull_d;
         txd_q      <= txd_d;
         done_q     <= done_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.uart_txd   = txd_q;
   assign bus.tx_busy    = (state_q != S_IDLE) || holdFull_q;
   assign bus.tx_done    = done_q;
   assign bus.tx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frame scenarios plus random traffic, compared every cycle against
// a frame-level model (byte queue + elapsed time within the frame).
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   uart_tx_if bus ();

   uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: one frame on the line, counted by time elapsed since its start bit began.
   bit         mActive;
   logic [7:0] mCur;
   int         mElapsed;
   bit         mHoldValid;
   logic [7:0] mHold;
   bit         mDone;
   bit         mOvr;
   bit         lineLog[$];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, observed, expected);
      end
   endtask

   function automatic logic expectedLine();
      int idx;
      if (!mActive) return 1'b1;
      idx = mElapsed / CPB;
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return mCur[idx-1];
   endfunction

   task automatic modelReset();
      mActive    = 0;
      mCur       = 8'h00;
      mElapsed   = 0;
      mHoldValid = 0;
      mHold      = 8'h00;
      mDone      = 0;
      mOvr       = 0;
   endtask

   task automatic compareAll(input string phase);
      checkOutput({phase, ".txd"},     32'(bus.uart_txd),   32'(expectedLine()));
      checkOutput({phase, ".busy"},    32'(bus.tx_busy),    32'(mActive || mHoldValid));
      checkOutput({phase, ".done"},    32'(bus.tx_done),    32'(mDone));
      checkOutput({phase, ".overrun"}, 32'(bus.tx_overrun), 32'(mOvr));
   endtask

   // Drive one cycle of inputs, step the model across the edge, then compare just after it.
   task automatic applyStimulus(input logic start, input logic [7:0] data, input logic clr);
      bit aOld, hOld, frameEnd;
      bus.tx_start   = start;
      bus.tx_data    = data;
      bus.status_clr = clr;
      @(posedge clk);
      aOld     = mActive;
      hOld     = mHoldValid;
      frameEnd = aOld && (mElapsed == FRAME - 1);
      if (aOld) begin
         if (!frameEnd) begin
            mElapsed++;
         end else if (hOld) begin
            mCur       = mHold;
            mElapsed   = 0;
            mHoldValid = 0;
         end else begin
            mActive = 0;
         end
      end else if (hOld) begin
         mActive    = 1;
         mCur       = mHold;
         mElapsed   = 0;
         mHoldValid = 0;
      end else if (start) begin
         mActive  = 1;
         mCur     = data;
         mElapsed = 0;
      end
      if (start && hOld) begin
         mOvr = 1;
      end else begin
         if (start && aOld) begin
            mHold      = data;
            mHoldValid = 1;
         end
         if (clr) mOvr = 0;
      end
      if (frameEnd) mDone = 1;
      else if (clr) mDone = 0;
      #1;
      compareAll("cyc");
      lineLog.push_back(bus.uart_txd);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom), 1'b0);
   endtask

   // Assert reset mid-cycle, check the outputs drop immediately, then release just after an edge.
   task automatic asyncReset();
      reset = 1'b1;
      modelReset();
      #1;
      compareAll("rst");
      bus.tx_start   = 1'b0;
      bus.status_clr = 1'b0;
      @(posedge clk);
      #1;
      compareAll("rstHeld");
      reset = 1'b0;
   endtask

   function automatic logic [7:0] decodeLog(input int startIdx);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = lineLog[startIdx + (i + 1) * CPB + CPB / 2];
      return b;
   endfunction

   initial begin
      checks         = 0;
      failures       = 0;
      bus.tx_start   = 1'b0;
      bus.tx_data    = 8'h00;
      bus.status_clr = 1'b0;
      reset          = 1'b1;
      modelReset();
      #12;
      compareAll("init");
      reset = 1'b0;
      idleCycles(3);

      // Single 0x55 frame, also decoded from the recorded line.
      lineLog.delete();
      applyStimulus(1'b1, 8'h55, 1'b0);
      idleCycles(44);
      checkOutput("dec55.start", 32'(lineLog[CPB/2]), 32'd0);
      checkOutput("dec55.data",  32'(decodeLog(0)),   32'h55);
      checkOutput("dec55.stop",  32'(lineLog[9*CPB + CPB/2]), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1);

      // Back-to-back frames through the holding register.
      lineLog.delete();
      applyStimulus(1'b1, 8'hA3, 1'b0);
      idleCycles(9);
      applyStimulus(1'b1, 8'h0F, 1'b0);
      idleCycles(85);
      checkOutput("b2b.first",  32'(decodeLog(0)),     32'hA3);
      checkOutput("b2b.gap",    32'(lineLog[FRAME]),   32'd0);
      checkOutput("b2b.second", 32'(decodeLog(FRAME)), 32'h0F);

      // Overrun: third request while holding is full is dropped.
      lineLog.delete();
      applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b1, 8'h11, 1'b0);
      idleCycles(3);
      applyStimulus(1'b1, 8'h22, 1'b0);
      applyStimulus(1'b1, 8'h33, 1'b0);
      idleCycles(90);
      checkOutput("ovr.first",  32'(decodeLog(1)),         32'h11);
      checkOutput("ovr.second", 32'(decodeLog(1 + FRAME)), 32'h22);
      checkOutput("ovr.idle",   32'(lineLog[1 + 2*FRAME]), 32'd1);

      // status_clr on the done-setting edge loses to the set; one cycle later it clears.
      applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b1, 8'h5A, 1'b0);
      idleCycles(FRAME - 1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("clr.setWins", 32'(bus.tx_done), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("clr.cleared", 32'(bus.tx_done), 32'd0);

      // Reset in the middle of a 0xFF frame with 0x80 held, then a clean 0x01 frame.
      applyStimulus(1'b1, 8'hFF, 1'b0);
      idleCycles(4);
      applyStimulus(1'b1, 8'h80, 1'b0);
      idleCycles(11);
      asyncReset();
      lineLog.delete();
      applyStimulus(1'b1, 8'h01, 1'b0);
      idleCycles(50);
      checkOutput("rst.clean", 32'(decodeLog(0)), 32'h01);
      checkOutput("rst.noResume", 32'(lineLog[FRAME + 2]), 32'd1);

      // Request on the very first edge after release.
      idleCycles(7);
      asyncReset();
      lineLog.delete();
      applyStimulus(1'b1, 8'h00, 1'b0);
      idleCycles(42);
      checkOutput("first.data", 32'(decodeLog(0)), 32'h00);
      checkOutput("first.stop", 32'(lineLog[FRAME - 1]), 32'd1);

      // Random traffic, with occasional resets.
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 999) == 0) asyncReset();
         applyStimulus(($urandom_range(0, 24) == 0), 8'($urandom), ($urandom_range(0, 14) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
